// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU control codes,
// sequencer state encoding and default datapath widths.
package alu_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_CTLW  = 4;

   localparam logic [ALU_CTLW-1:0] ALU_AND = 4'd0;
   localparam logic [ALU_CTLW-1:0] ALU_OR  = 4'd1;
   localparam logic [ALU_CTLW-1:0] ALU_ADD = 4'd2;
   localparam logic [ALU_CTLW-1:0] ALU_SUB = 4'd6;
   localparam logic [ALU_CTLW-1:0] ALU_SLT = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, on contention
// the requester named by pointer wins. Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] grant
);

   for (genvar gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = req[gi] & (~req[1-gi] | (pointer == 1'(gi)));
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external ALU between two requesters: round-robin accept,
// one-cycle execute, then hold the registered result until the owner takes it.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int CTLW  = ALU_CTLW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [CTLW-1:0]  r0_ctl,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [CTLW-1:0]  r1_ctl,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   output logic             r0_rvalid,
   input  logic             r0_rready,
   output logic             r1_rvalid,
   input  logic             r1_rready,
   output logic [WIDTH-1:0] resp_out,
   output logic             resp_zero,
   output logic [CTLW-1:0]  alu_ctl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   output logic             busy
);

   state_t           state_reg;
   logic             ptr_reg;
   logic             owner_reg;
   logic [CTLW-1:0]  ctl_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] resp_out_reg;
   logic             resp_zero_reg;
   logic [1:0]       rvalid_reg;
   logic             busy_reg;

   logic [1:0]       grant;
   logic [1:0]       ready;
   logic             owner_rready;

   rr_arb2 u_arb (
      .req     ({r1_valid, r0_valid}),
      .pointer (ptr_reg),
      .grant   (grant)
   );

   // Ready is also held low while reset is asserted so nothing looks accepted.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready[gi] = (state_reg == IDLE) & grant[gi] & ~reset;
   end

   assign owner_rready = owner_reg ? r1_rready : r0_rready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         ptr_reg       <= 1'b0;
         owner_reg     <= 1'b0;
         ctl_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         resp_out_reg  <= '0;
         resp_zero_reg <= 1'b0;
         rvalid_reg    <= 2'b00;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|ready) begin
                  ctl_reg   <= ready[1] ? r1_ctl : r0_ctl;
                  a_reg     <= ready[1] ? r1_a   : r0_a;
                  b_reg     <= ready[1] ? r1_b   : r0_b;
                  owner_reg <= ready[1];
                  busy_reg  <= 1'b1;
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               resp_out_reg  <= alu_out;
               resp_zero_reg <= alu_zero;
               rvalid_reg    <= owner_reg ? 2'b10 : 2'b01;
               state_reg     <= RESP;
            end
            RESP: begin
               // The non-owner's rready is deliberately ignored here.
               if (owner_rready) begin
                  rvalid_reg <= 2'b00;
                  ptr_reg    <= ~owner_reg;
                  busy_reg   <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign r0_ready  = ready[0];
   assign r1_ready  = ready[1];
   assign r0_rvalid = rvalid_reg[0];
   assign r1_rvalid = rvalid_reg[1];
   assign resp_out  = resp_out_reg;
   assign resp_zero = resp_zero_reg;
   assign alu_ctl   = ctl_reg;
   assign alu_a     = a_reg;
   assign alu_b     = b_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter with a transaction-level
// reference model and an external ALU model wired to the ALU ports.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        r0_valid = 1'b0, r1_valid = 1'b0;
   logic        r0_ready, r1_ready;
   logic [3:0]  r0_ctl = '0, r1_ctl = '0;
   logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
   logic        r0_rvalid, r1_rvalid;
   logic        r0_rready = 1'b0, r1_rready = 1'b0;
   logic [31:0] resp_out;
   logic        resp_zero;
   logic [3:0]  alu_ctl;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_zero;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference model: whether an operation is outstanding, its phase,
   // who owns it, whose turn it is on contention, and expected outputs.
   logic        m_busy = 0, m_exec = 0, m_have = 0, m_owner = 0, m_prio = 0;
   logic [3:0]  m_ctl = '0;
   logic [31:0] m_a = '0, m_b = '0, m_resp = '0;
   logic        m_zero = 0;
   logic [31:0] exp_q[$];

   alu_share_arbiter dut (
      .clock(clock), .reset(reset),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_ctl(r0_ctl), .r0_a(r0_a), .r0_b(r0_b),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_ctl(r1_ctl), .r1_a(r1_a), .r1_b(r1_b),
      .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
      .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
      .resp_out(resp_out), .resp_zero(resp_zero),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      case (c)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return b;
      endcase
   endfunction

   assign alu_out  = ref_alu(alu_ctl, alu_a, alu_b);
   assign alu_zero = (alu_out == 32'd0);

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: check mid-cycle against the model, advance the model with the
   // handshakes seen at the coming edge, and withdraw any accepted request.
   task automatic cycle();
      logic e0, e1;
      #4;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!reset && !m_busy) begin
         if (r0_valid && (!r1_valid || m_prio == 1'b0)) e0 = 1'b1;
         else if (r1_valid) e1 = 1'b1;
      end
      chk("r0_ready", r0_ready, e0);
      chk("r1_ready", r1_ready, e1);
      chk("busy", busy, m_busy);
      chk("r0_rvalid", r0_rvalid, m_have && !m_owner);
      chk("r1_rvalid", r1_rvalid, m_have && m_owner);
      chk("resp_out", resp_out, m_resp);
      chk("resp_zero", resp_zero, m_zero);
      chk("alu_ctl", alu_ctl, m_ctl);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (reset) begin
         m_busy = 0; m_exec = 0; m_have = 0; m_owner = 0; m_prio = 0;
         m_ctl = '0; m_a = '0; m_b = '0; m_resp = '0; m_zero = 0;
         exp_q.delete();
      end else if (e0 || e1) begin
         m_busy  = 1;
         m_exec  = 1;
         m_owner = e1;
         m_ctl   = e1 ? r1_ctl : r0_ctl;
         m_a     = e1 ? r1_a : r0_a;
         m_b     = e1 ? r1_b : r0_b;
         exp_q.push_back(ref_alu(m_ctl, m_a, m_b));
      end else if (m_exec) begin
         m_exec = 0;
         m_have = 1;
         m_resp = ref_alu(m_ctl, m_a, m_b);
         m_zero = (m_resp == 32'd0);
      end else if (m_have && (m_owner ? r1_rready : r0_rready)) begin
         if (exp_q.size() > 0) chk("scoreboard", resp_out, exp_q.pop_front());
         m_have = 0;
         m_busy = 0;
         m_prio = ~m_owner;
      end
      @(posedge clock);
      #1;
      if (e0) r0_valid = 1'b0;
      if (e1) r1_valid = 1'b0;
   endtask

   task automatic req0(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      r0_valid = 1'b1; r0_ctl = c; r0_a = a; r0_b = b;
   endtask

   task automatic req1(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      r1_valid = 1'b1; r1_ctl = c; r1_a = a; r1_b = b;
   endtask

   initial begin
      @(posedge clock);
      #1;
      // Reset, then idle outputs
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_busy", busy, 32'd0);
      chk("rst_alu_ctl", alu_ctl, 32'd0);
      chk("rst_resp", resp_out, 32'd0);
      cycle();

      // r0 ADD(5,7) with latency and spacing
      r0_rready = 1'b1;
      req0(ALU_ADD, 32'd5, 32'd7);
      cycle();
      cycle();
      chk("add_rvalid", r0_rvalid, 32'd1);
      chk("add_result", resp_out, 32'd12);
      chk("add_zero", resp_zero, 32'd0);
      req0(ALU_ADD, 32'd1, 32'd1);
      for (int i = 0; i < 4; i++) cycle();

      // Contention right after reset: r0 first, then r1
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      r1_rready = 1'b1;
      req0(ALU_SUB, 32'd9, 32'd9);
      req1(ALU_OR, 32'hF0, 32'h0F);
      cycle();
      cycle();
      chk("sub_rvalid", r0_rvalid, 32'd1);
      chk("sub_result", resp_out, 32'd0);
      chk("sub_zero", resp_zero, 32'd1);
      cycle();
      cycle();
      cycle();
      chk("or_rvalid", r1_rvalid, 32'd1);
      chk("or_result", resp_out, 32'hFF);
      cycle();
      req0(ALU_ADD, 32'd3, 32'd4);
      req1(ALU_ADD, 32'd10, 32'd20);
      for (int i = 0; i < 8; i++) cycle();

      // Backpressure on r1 with stray r0_rready pulses
      r1_rready = 1'b0;
      r0_rready = 1'b0;
      req1(ALU_SLT, 32'd3, 32'd4);
      cycle();
      cycle();
      req0(ALU_ADD, 32'd2, 32'd2);
      for (int i = 0; i < 5; i++) begin
         r0_rready = ~r0_rready;
         cycle();
         chk("bp_rvalid", r1_rvalid, 32'd1);
         chk("bp_result", resp_out, 32'd1);
      end
      r1_rready = 1'b1;
      r0_rready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();

      // r1 back-to-back ANDs with r0 idle
      for (int i = 0; i < 4; i++) begin
         req1(ALU_AND, 32'hFF00 | i, 32'h0FF0);
         cycle();
         cycle();
         chk("b2b_rvalid", r1_rvalid, 32'd1);
         chk("b2b_result", resp_out, 32'h0F00);
         cycle();
      end

      // Unsupported code returns operand B
      req0(4'hF, 32'd1, 32'h1234);
      cycle();
      cycle();
      chk("unsup_rvalid", r0_rvalid, 32'd1);
      chk("unsup_result", resp_out, 32'h1234);
      cycle();

      // Reset while holding a response
      r0_rready = 1'b0;
      req0(ALU_ADD, 32'd1, 32'd2);
      cycle();
      cycle();
      chk("rr_rvalid_pre", r0_rvalid, 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rr_rvalid_post", r0_rvalid, 32'd0);
      chk("rr_busy_post", busy, 32'd0);
      r0_rready = 1'b1;
      for (int i = 0; i < 3; i++) cycle();

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         if (!r0_valid && $urandom_range(0, 2) == 0)
            req0(4'($urandom_range(0, 15)), $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                 32'($urandom_range(0, 3)));
         else if (r0_valid && m_busy && $urandom_range(0, 9) == 0)
            r0_valid = 1'b0;
         if (!r1_valid && $urandom_range(0, 2) == 0)
            req1(4'($urandom_range(0, 15)), $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)),
                 32'($urandom_range(0, 3)));
         else if (r1_valid && m_busy && $urandom_range(0, 9) == 0)
            r1_valid = 1'b0;
         r0_rready = 1'($urandom_range(0, 1));
         r1_rready = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 59) == 0);
         cycle();
      end
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one ALU instance between two requesters, e.g. requester 0 = EX-stage datapath and requester 1 = branch/address-compare unit.
- Arbitrates round-robin, sequences a single operation through the ALU, registers the result, and returns it on a valid/ready response handshake.
- Sits between the requesters and the ALU's control, operand, result and zero ports.
- One operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width (matches ALU datapath).
- CTLW, 4, ALU control code width.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_ctl  in  CTLW  requester 0 ALU control code
- r0_a  in  WIDTH  requester 0 operand A
- r0_b  in  WIDTH  requester 0 operand B
- r1_valid, r1_ready, r1_ctl, r1_a, r1_b: same as above, for requester 1
- r0_rvalid  out  1  result for requester 0 available
- r0_rready  in  1  requester 0 takes result
- r1_rvalid  out  1  result for requester 1 available
- r1_rready  in  1  requester 1 takes result
- resp_out  out  WIDTH  registered ALU result (shared bus)
- resp_zero  out  1  registered ALU zero flag
- alu_ctl  out  CTLW  to ALU control input
- alu_a  out  WIDTH  to ALU operand A
- alu_b  out  WIDTH  to ALU operand B
- alu_out  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: wait for a request.
  - EXEC: ALU evaluates the latched operands.
  - RESP: hold the result until the owning requester takes it.
- Reset (synchronous, active-high), all at the edge where reset is sampled high:
  - state=IDLE, priority pointer=0, owner=0.
  - Operand registers ctl/a/b=0, so alu_ctl=0, alu_a=0, alu_b=0.
  - resp_out=0, resp_zero=0, r0/r1_rvalid=0, r0/r1_ready=0, busy=0.
  - Reset during EXEC or RESP discards the operation; no response is ever issued for it.
- Grant (combinational, IDLE only):
  - If only one requester's valid is high, it wins.
  - If both are high, the requester named by the priority pointer wins.
  - rN_ready = (state==IDLE) & grantN. At most one ready is high per cycle.
  - ready may depend on valid; valid must not depend on ready.
- Accept (IDLE, rN_valid & rN_ready at edge):
  - Latch rN_ctl/a/b into the operand registers and owner=N.
  - Next state is EXEC.
- EXEC (exactly 1 cycle):
  - alu_ctl/a/b are driven from the operand registers. They are always driven from them, holding the last values in other states.
  - At the edge: resp_out<=alu_out, resp_zero<=alu_zero, next state RESP.
  - ALU codes are passed through unchecked; unsupported codes yield whatever the ALU returns (operand B).
- RESP:
  - r{owner}_rvalid=1; the other rvalid stays 0.
  - resp_out/resp_zero are stable until the handshake completes.
  - On r{owner}_rready at the edge: state=IDLE, priority pointer = the other requester.
  - rready from the non-owner is ignored.
- Timing:
  - Latency: accept at edge N, rvalid high from cycle after edge N+1.
  - Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with rready already high).
- Boundary cases:
  - Requests arriving during EXEC/RESP are stalled (ready=0); operands must be held stable by the requester per handshake.
  - Starvation-free: after a serviced request, the other requester has priority.
  - A single requester can issue back-to-back operations indefinitely when the other stays idle.
  - valid deasserted while ready=0 is legal; nothing is latched.

Decomposition:
- Shared package alu_pkg:
  - ALU control constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7.
  - State encoding: IDLE, EXEC, RESP.
  - Default WIDTH and CTLW.
- One natural sub-module: rr_arb2, the 2-way round-robin grant logic.
  - Inputs: req[1:0], pointer.
  - Output: one-hot grant.
- The ALU itself is instantiated outside this block alongside it, not inside it.

Test Plan:
- Reset then idle: all outputs 0, busy=0, alu_ctl=0; assert reset while in RESP -> rvalid drops next cycle, state IDLE, no response issued.
- r0 ADD (ctl=2, a=5, b=7), r0_rready=1 -> r0_ready 1 cycle, r0_rvalid=1 two cycles later with resp_out=12, resp_zero=0; next accept no earlier than 3 cycles after the first.
- Simultaneous r0 SUB(9,9) and r1 OR(0xF0,0x0F) after reset -> r0 served first (resp_out=0, resp_zero=1), then r1 (resp_out=0xFF); the pointer alternates on further contention.
- Backpressure: r1 SLT(3,4) with r1_rready held 0 for 5 cycles -> r1_rvalid and resp_out=1 stay stable, both readies stay 0; r0_rready pulses during this period are ignored.
- r1 issues 4 back-to-back ANDs while r0 is idle -> all served in order, each 3 cycles apart with rready high.
- Unsupported code ctl=0xF, a=1, b=0x1234 -> resp_out=0x1234 returned to the owner.
